pc_fetch_sequencer: RTL

- Owns the fetch program counter and sequences instruction fetch over a stall-capable request/ready instruction-memory port.
- Presents fetched instructions to decode through a valid/ready handshake.
- Applies branch/jump/exception redirects from later stages, including squashing a fetch already in flight.
- Replaces the free-running PC register for configurations where instruction memory can insert wait states.

---
 rtl/pc_fetch_sequencer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pc_fetch_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// pc_fetch_sequencer: fetch PC owner with stall-tolerant imem port, decode
// handshake and redirect/squash handling.            Revision: 1.0
// ============================================================================
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] FAULT_VECTOR = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        fetch_fault,
  output logic [31:0] pc
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] FLUSH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        fault_q, fault_d;
  logic        tgt_misaligned;
  logic [31:0] tgt;

  assign tgt_misaligned = (redirect_target[1:0] != 2'b00);
  assign tgt            = tgt_misaligned ? FAULT_VECTOR : redirect_target;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_d        = pend_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    fault_d       = redirect_valid && tgt_misaligned;

    case (state_q)
      FETCH: begin
        if (imem_ready) begin
          if (redirect_valid) begin
            pc_d = tgt;
          end else begin
            instr_d       = imem_rdata;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + 32'd4;
            state_d       = HOLD;
          end
        end else if (redirect_valid) begin
          // Address must stay put until memory completes the squashed fetch.
          pend_d  = tgt;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (imem_ready) begin
          pc_d    = redirect_valid ? tgt : pend_q;
          state_d = FETCH;
        end else if (redirect_valid) begin
          pend_d = tgt;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          instr_valid_d = 1'b0;
          pc_d          = tgt;
          state_d       = FETCH;
        end else if (instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      pc_q          <= RESET_VECTOR;
      pend_q        <= 32'd0;
      instr_q       <= 32'd0;
      instr_pc_q    <= 32'd0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_q        <= pend_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
    end
  end

  assign imem_req    = !reset && ((state_q == FETCH) || (state_q == FLUSH));
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign fetch_fault = fault_q;

endmodule
`default_nettype wire
